resizer_lane_buffer: RTL and testbench

//  Upstream stage of the resizer output path. Accepts AXI-Stream-like beats of S_KEEP_WIDTH lanes.

---
 rtl/resizer_lane_buffer_if.sv | 32 +++
 rtl/resizer_lane_buffer.sv | 119 +++++++++++
 tb/tb_resizer_lane_buffer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/resizer_lane_buffer_if.sv
// rtl/resizer_lane_buffer_if.sv - stream-in / entry-out bundle for the resizer lane buffer
//
// Purpose: groups the input beat handshake and the packed output entry handshake.
// Ports (signals):
//   s_valid_i, s_ready_o, s_last_i, s_keep_i, s_data_i : input beat stream
//   master_entry, underflow, master_entry_ready        : packed entry towards the output stage
// Modports: master = beat source / entry consumer, slave = lane buffer.
interface resizer_lane_buffer_if #(
  parameter int S_KEEP_WIDTH     = 3,
  parameter int T_DATA_WIDTH     = 1,
  parameter int M_KEEP_WIDTH     = 2,
  parameter int BUF_OUT_ENTRY_SZ = (2 + T_DATA_WIDTH) * M_KEEP_WIDTH
);
  logic                                   s_valid_i;
  logic                                   s_ready_o;
  logic                                   s_last_i;
  logic [S_KEEP_WIDTH-1:0]                s_keep_i;
  logic [S_KEEP_WIDTH*T_DATA_WIDTH-1:0]   s_data_i;
  logic [BUF_OUT_ENTRY_SZ-1:0]            master_entry;
  logic                                   underflow;
  logic                                   master_entry_ready;

  modport master (
    output s_valid_i, s_last_i, s_keep_i, s_data_i, master_entry_ready,
    input  s_ready_o, master_entry, underflow
  );

  modport slave (
    input  s_valid_i, s_last_i, s_keep_i, s_data_i, master_entry_ready,
    output s_ready_o, master_entry, underflow
  );
endinterface

// File: rtl/resizer_lane_buffer.sv
// rtl/resizer_lane_buffer.sv - compacts kept input lanes into a circular store and presents packed entries
//
// Purpose: accepts sparse-keep beats, stores kept lanes contiguously (data + last) and presents up to
// M_KEEP_WIDTH lanes as one entry that never crosses a packet boundary.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   bus    : resizer_lane_buffer_if.slave (input beats, packed entry, underflow, pop request)
//   err_o  : one-cycle pulse after a null beat carrying last
module resizer_lane_buffer #(
  parameter int S_KEEP_WIDTH     = 3,
  parameter int T_DATA_WIDTH     = 1,
  parameter int M_KEEP_WIDTH     = 2,
  parameter int DEPTH            = 8,
  parameter int BUF_OUT_ENTRY_SZ = (2 + T_DATA_WIDTH) * M_KEEP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  resizer_lane_buffer_if.slave  bus,
  output logic                  err_o
);

  localparam int LW = 2 + T_DATA_WIDTH;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [T_DATA_WIDTH-1:0] data_q [DEPTH];
  logic [T_DATA_WIDTH-1:0] data_d [DEPTH];
  logic                    last_q [DEPTH];
  logic                    last_d [DEPTH];
  logic                    err_q, err_d;

  logic                        s_ready;
  logic                        push, pop;
  logic [BUF_OUT_ENTRY_SZ-1:0] entry;
  logic                        uflow;
  logic                        blocked, tail_last;
  int                          p_lanes, n_lanes;

  // Pointer advance with explicit wrap; off never exceeds DEPTH so one correction suffices.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  // Room for a worst-case (all lanes kept) beat, judged on registered count only.
  assign s_ready = !rst && (int'(count_q) <= DEPTH - S_KEEP_WIDTH);
  assign push    = bus.s_valid_i && s_ready;
  assign pop     = bus.master_entry_ready && !uflow;

  // Presented entry: lanes stop after the first stored last so entries never span packets.
  always_comb begin
    entry     = '0;
    p_lanes   = 0;
    blocked   = 1'b0;
    tail_last = 1'b0;
    for (int k = 0; k < M_KEEP_WIDTH; k++) begin
      if (!rst && !blocked && k < int'(count_q)) begin
        entry[k*LW +: LW] = {data_q[wrap_add(rd_ptr_q, k)], last_q[wrap_add(rd_ptr_q, k)], 1'b1};
        p_lanes           = k + 1;
        tail_last         = last_q[wrap_add(rd_ptr_q, k)];
        blocked           = tail_last;
      end
    end
    // A short entry is only complete when it ends its packet.
    uflow = (p_lanes == 0) || (p_lanes < M_KEEP_WIDTH && !tail_last);
  end

  // Store update: kept lanes are written densely; last goes only on the highest kept lane.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    n_lanes = 0;
    if (push) begin
      for (int i = 0; i < S_KEEP_WIDTH; i++) begin
        if (bus.s_keep_i[i]) begin
          data_d[wrap_add(wr_ptr_q, n_lanes)] = bus.s_data_i[i*T_DATA_WIDTH +: T_DATA_WIDTH];
          last_d[wrap_add(wr_ptr_q, n_lanes)] = bus.s_last_i && ((bus.s_keep_i >> (i + 1)) == '0);
          n_lanes = n_lanes + 1;
        end
      end
    end
    wr_ptr_d = wrap_add(wr_ptr_q, n_lanes);
    rd_ptr_d = pop ? wrap_add(rd_ptr_q, p_lanes) : rd_ptr_q;
    count_d  = CW'(int'(count_q) + n_lanes - (pop ? p_lanes : 0));
    err_d    = push && (bus.s_keep_i == '0) && bus.s_last_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

  assign bus.s_ready_o    = s_ready;
  assign bus.master_entry = entry;
  assign bus.underflow    = uflow;
  assign err_o            = err_q && !rst;

endmodule

// File: tb/tb_resizer_lane_buffer.sv
// tb/tb_resizer_lane_buffer.sv - scoreboard bench for resizer_lane_buffer
module tb_resizer_lane_buffer;

  localparam int S  = 3;
  localparam int TW = 8;
  localparam int M  = 2;
  localparam int D  = 8;
  localparam int ES = (2 + TW) * M;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;

  int total = 0;
  int bad   = 0;

  logic [ES-1:0] exp_q[$];

  resizer_lane_buffer_if #(.S_KEEP_WIDTH(S), .T_DATA_WIDTH(TW), .M_KEEP_WIDTH(M)) bus ();

  resizer_lane_buffer #(
    .S_KEEP_WIDTH(S), .T_DATA_WIDTH(TW), .M_KEEP_WIDTH(M), .DEPTH(D)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .err_o (err)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] ln(input logic l, input logic [7:0] d);
    return {d, l, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every real pop (ready && !underflow, outside reset) is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && bus.master_entry_ready && !bus.underflow) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_entry actual=%h required=none", bus.master_entry);
      end else begin
        chk("entry", 32'(bus.master_entry), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [2:0] keep, input logic last, input logic [23:0] data);
    bit done;
    done = 0;
    bus.s_valid_i = 1'b1;
    bus.s_keep_i  = keep;
    bus.s_last_i  = last;
    bus.s_data_i  = data;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (bus.s_ready_o) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
    bus.s_valid_i = 1'b0;
    bus.s_keep_i  = '0;
    bus.s_last_i  = 1'b0;
    bus.s_data_i  = '0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.s_valid_i          = 1'b0;
    bus.s_last_i           = 1'b0;
    bus.s_keep_i           = '0;
    bus.s_data_i           = '0;
    bus.master_entry_ready = 1'b0;

    // 1: reset and idle
    @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", 32'(bus.s_ready_o), 32'd1);
    chk("idle_underflow", 32'(bus.underflow), 32'd1);
    chk("idle_entry", 32'(bus.master_entry), 32'd0);
    chk("idle_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 bus.master_entry_ready = 1'b1;

    // 2: full beat, partial remainder held, then terminated
    exp_q.push_back({ln(0, 8'hB2), ln(0, 8'hA1)});
    send(3'b111, 1'b0, {8'hC3, 8'hB2, 8'hA1});
    repeat (3) @(negedge clk);
    chk("held_underflow", 32'(bus.underflow), 32'd1);
    chk("held_entry", 32'(bus.master_entry), 32'({10'd0, ln(0, 8'hC3)}));
    @(posedge clk);
    #1;
    exp_q.push_back({ln(1, 8'hD4), ln(0, 8'hC3)});
    send(3'b001, 1'b1, {8'h00, 8'h00, 8'hD4});

    // 3: sparse keep, dropped lane leaves no gap
    exp_q.push_back({ln(1, 8'h5A), ln(0, 8'h58)});
    send(3'b101, 1'b1, {8'h5A, 8'hEE, 8'h58});

    // 4: packet boundary splits entries
    exp_q.push_back({ln(0, 8'h12), ln(0, 8'h11)});
    exp_q.push_back({10'd0, ln(1, 8'h13)});
    exp_q.push_back({ln(0, 8'h15), ln(0, 8'h14)});
    exp_q.push_back({ln(1, 8'h17), ln(0, 8'h16)});
    send(3'b111, 1'b1, {8'h13, 8'h12, 8'h11});
    send(3'b111, 1'b0, {8'h16, 8'h15, 8'h14});
    send(3'b001, 1'b1, {8'h00, 8'h00, 8'h17});
    drain();

    // 5: fill with consumer stalled, then release across pointer wrap
    bus.master_entry_ready = 1'b0;
    exp_q.push_back({ln(0, 8'h02), ln(0, 8'h01)});
    exp_q.push_back({ln(0, 8'h04), ln(0, 8'h03)});
    exp_q.push_back({ln(0, 8'h06), ln(0, 8'h05)});
    exp_q.push_back({ln(0, 8'h08), ln(0, 8'h07)});
    exp_q.push_back({10'd0, ln(1, 8'h09)});
    send(3'b111, 1'b0, {8'h03, 8'h02, 8'h01});
    send(3'b111, 1'b0, {8'h06, 8'h05, 8'h04});
    @(negedge clk);
    chk("full_s_ready", 32'(bus.s_ready_o), 32'd0);
    chk("full_underflow", 32'(bus.underflow), 32'd0);
    chk("full_entry", 32'(bus.master_entry), 32'({ln(0, 8'h02), ln(0, 8'h01)}));
    @(posedge clk);
    #1 bus.master_entry_ready = 1'b1;
    send(3'b111, 1'b1, {8'h09, 8'h08, 8'h07});
    drain();

    // 6: null beat with last, then reset mid-packet
    bus.master_entry_ready = 1'b0;
    send(3'b001, 1'b0, {8'h00, 8'h00, 8'h4D});
    send(3'b000, 1'b1, 24'h000000);
    @(negedge clk);
    chk("null_err_pulse", 32'(err), 32'd1);
    chk("null_entry", 32'(bus.master_entry), 32'({10'd0, ln(0, 8'h4D)}));
    @(negedge clk);
    chk("null_err_clear", 32'(err), 32'd0);
    chk("null_count_kept", 32'(bus.master_entry), 32'({10'd0, ln(0, 8'h4D)}));
    chk("null_underflow", 32'(bus.underflow), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready", 32'(bus.s_ready_o), 32'd0);
    chk("midrst_underflow", 32'(bus.underflow), 32'd1);
    chk("midrst_entry", 32'(bus.master_entry), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_underflow", 32'(bus.underflow), 32'd1);
    chk("postrst_entry", 32'(bus.master_entry), 32'd0);
    chk("postrst_s_ready", 32'(bus.s_ready_o), 32'd1);
    @(posedge clk);
    #1 bus.master_entry_ready = 1'b1;
    exp_q.push_back({ln(1, 8'h62), ln(0, 8'h61)});
    send(3'b011, 1'b1, {8'h00, 8'h62, 8'h61});
    drain();
    repeat (2) @(negedge clk);
    chk("final_underflow", 32'(bus.underflow), 32'd1);
    chk("final_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
